hilo_ctrl: RTL and testbench
============================

HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 33, meaning the number of cycles to wait after the mult_op pulse before sampling the product (legal range 1..63).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to launch one multiply, sampled in IDLE only.
REQ-005 SHALL have port mult_op  output  1  one-cycle launch pulse to the multiplier.
REQ-006 SHALL have ports mult_hi_in, mult_lo_in  input  32 each  product halves returned by the multiplier.
REQ-007 SHALL have ports mthi, mtlo  input  1 each  write requests for HI and LO.
REQ-008 SHALL have port wdata  input  32  data for mthi/mtlo.
REQ-009 SHALL have ports mfhi, mflo  input  1 each  read requests for HI and LO.
REQ-010 SHALL have port rdata  output  32  registered read data.
REQ-011 SHALL have ports busy, done, stall  output  1 each  status: operation in flight, product captured (one-cycle pulse), read/write refused.
REQ-012 SHALL have ports hi, lo  output  32 each  current HI/LO register contents.

Function
REQ-013 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> CAPTURE -> IDLE.
REQ-014 SHALL go IDLE->LAUNCH when start=1, and hold in IDLE otherwise.
REQ-015 SHALL drive mult_op=1 in LAUNCH only, then enter WAIT with the counter loaded to LATENCY-1.
REQ-016 SHALL decrement the 6-bit counter each WAIT cycle and enter CAPTURE when it is 0.
REQ-017 SHALL in CAPTURE load hi<=mult_hi_in and lo<=mult_lo_in, pulse done=1, and return to IDLE.
REQ-018 SHALL assert busy in LAUNCH, WAIT and CAPTURE; start while busy is ignored and not queued.
REQ-019 SHALL, in IDLE, write wdata to HI on mthi and to LO on mtlo, with both allowed in the same cycle.
REQ-020 SHALL, when mthi/mtlo arrive while busy, drop the write and assert stall that cycle.
REQ-021 SHALL, in IDLE, return HI on mfhi (which has priority over mflo) and LO on mflo, in rdata on the next edge.
REQ-022 SHALL, when mfhi/mflo arrive while busy, assert stall combinationally and leave rdata unchanged.
REQ-023 SHALL, on mthi/mtlo plus mfhi/mflo to the same register in one IDLE cycle, return the old value.
REQ-024 SHALL, on start plus mthi/mtlo in one IDLE cycle, perform the write, launch, and let CAPTURE overwrite.
REQ-025 SHALL keep total start-to-done latency at LATENCY+2 cycles.

Reset
REQ-026 SHALL on rst_n=0 immediately force IDLE, counter=0, hi=lo=rdata=0, and mult_op=busy=done=0.
REQ-027 SHALL on reset mid-operation abandon the product, with no done pulse after release.
REQ-028 SHALL derive stall combinationally from state, so it is 0 during reset.

Configuration
REQ-029 SHALL, with HILO_BYPASS_EN defined, serve mfhi/mflo in CAPTURE without stall and return mult_hi_in/mult_lo_in directly.
REQ-030 SHALL, without HILO_BYPASS_EN, stall reads in CAPTURE like any busy state.

Structure
REQ-031 SHALL take the state encoding (typedef hilo_state_t) and the counter width constant HILO_CNT_W from shared package hilo_pkg.
REQ-032 SHALL be a single module with no sub-modules; the FSM and counter are inline.

Verification
REQ-033 SHALL cover: start, mult_hi_in=0x00000001, mult_lo_in=0xFFFFFFFE, LATENCY=33 -> mult_op pulse at cycle 1, done at cycle 35, hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 SHALL cover: IDLE mthi with wdata=0xDEADBEEF, then mfhi -> rdata=0xDEADBEEF one cycle later, stall=0.
REQ-035 SHALL cover: mflo issued 5 cycles after start -> stall=1 and rdata unchanged until done; retry after done returns the new lo.
REQ-036 SHALL cover: second start during WAIT -> ignored, exactly one mult_op pulse and one done pulse.
REQ-037 SHALL cover: rst_n low during WAIT -> hi=lo=0, busy=0, and no done after release.
REQ-038 SHALL cover: with HILO_BYPASS_EN, mfhi in CAPTURE with mult_hi_in=0x12345678 -> stall=0 and rdata=0x12345678.

Source files
------------

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared state encoding, counter width and helpers for the HI/LO controller
package hilo_pkg;

  localparam int HILO_CNT_W = 6;
  localparam int HILO_DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } hilo_state_t;

  // Any state other than IDLE owns the HI/LO pair.
  function automatic logic hilo_busy_state(input hilo_state_t st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO register file with multiplier launch/wait/capture sequencer
// Optional feature: HILO_BYPASS_EN lets reads in CAPTURE return the incoming product directly.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int LATENCY = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        mult_op,
  input  logic [31:0] mult_hi_in,
  input  logic [31:0] mult_lo_in,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        mfhi,
  input  logic        mflo,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [HILO_CNT_W-1:0] CNT_LOAD = HILO_CNT_W'(LATENCY - 1);
  localparam logic [HILO_CNT_W-1:0] CNT_ONE  = HILO_CNT_W'(1);

  hilo_state_t           state;
  logic [HILO_CNT_W-1:0] cnt;

  logic rd_req;
  logic wr_req;
  logic rd_stall;
  logic wr_stall;

  assign rd_req = mfhi | mflo;
  assign wr_req = mthi | mtlo;

`ifdef HILO_BYPASS_EN
  assign rd_stall = rd_req && hilo_busy_state(state) && (state != ST_CAPTURE);
`else
  assign rd_stall = rd_req && hilo_busy_state(state);
`endif
  assign wr_stall = wr_req && hilo_busy_state(state);

  // Depends only on state and request inputs, so reset (forcing IDLE) clears it.
  assign stall = rd_stall | wr_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      rdata   <= '0;
      mult_op <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      mult_op <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Reads sample the pre-edge contents, so a same-cycle write returns the old value.
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (mfhi)      rdata <= hi;
          else if (mflo) rdata <= lo;
          if (start) begin
            state   <= ST_LAUNCH;
            mult_op <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          state <= ST_WAIT;
          cnt   <= CNT_LOAD;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_CAPTURE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_CAPTURE: begin
          hi    <= mult_hi_in;
          lo    <= mult_lo_in;
          busy  <= 1'b0;
          state <= ST_IDLE;
`ifdef HILO_BYPASS_EN
          if (mfhi)      rdata <= mult_hi_in;
          else if (mflo) rdata <= mult_lo_in;
`endif
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - directed self-checking bench for hilo_ctrl (honours HILO_BYPASS_EN)
module tb_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mult_op;
  logic [31:0] mult_hi_in = '0;
  logic [31:0] mult_lo_in = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        mfhi = 1'b0;
  logic        mflo = 1'b0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;

  hilo_ctrl #(.LATENCY(33)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mult_op(mult_op),
    .mult_hi_in(mult_hi_in), .mult_lo_in(mult_lo_in),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mfhi(mfhi), .mflo(mflo),
    .rdata(rdata), .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    mfhi = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if ({mult_op, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {mult_op, busy, done}); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    mfhi = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult;
    int op_cyc, done_cyc, op_n, done_n, busy_err;
    op_cyc = -1; done_cyc = -1; op_n = 0; done_n = 0; busy_err = 0;
    @(negedge clk);
    mult_hi_in = 32'h0000_0001;
    mult_lo_in = 32'hFFFF_FFFE;
    start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mult_op === 1'b1) begin op_n++; if (op_cyc < 0) op_cyc = k; end
      if (done === 1'b1) begin done_n++; if (done_cyc < 0) done_cyc = k; end
      if (k <= 35 && busy !== 1'b1) busy_err++;
      if (k == 36 && busy !== 1'b0) busy_err++;
    end
    total++; if (op_cyc != 1) begin bad++; $display("FAIL mult_op_cycle got=%0d exp=1", op_cyc); end
    total++; if (done_cyc != 35) begin bad++; $display("FAIL done_cycle got=%0d exp=35", done_cyc); end
    total++; if (op_n != 1 || done_n != 1) begin bad++; $display("FAIL mult_pulse_count got=%0d/%0d exp=1/1", op_n, done_n); end
    total++; if (busy_err != 0) begin bad++; $display("FAIL mult_busy got=%0d errors exp=0", busy_err); end
    total++; if (hi !== 32'h0000_0001) begin bad++; $display("FAIL mult_hi got=%h exp=00000001", hi); end
    total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end
  endtask

  task automatic test_write_read;
    @(negedge clk);
    wdata = 32'hDEAD_BEEF; mthi = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL wr_stall got=%b exp=0", stall); end
    @(negedge clk);
    mthi = 1'b0; mfhi = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rd_stall got=%b exp=0", stall); end
    total++; if (hi !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_hi got=%h exp=deadbeef", hi); end
    @(negedge clk);
    mfhi = 1'b0;
    total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_hi got=%h exp=deadbeef", rdata); end
    // both writes plus read of LO in one cycle: old LO comes back
    wdata = 32'hA5A5_A5A5; mthi = 1'b1; mtlo = 1'b1; mflo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; mflo = 1'b0;
    total++; if (rdata !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rd_old_lo got=%h exp=fffffffe", rdata); end
    total++; if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5) begin bad++; $display("FAIL dual_write got=%h/%h exp=a5a5a5a5/a5a5a5a5", hi, lo); end
    wdata = 32'h1357_9BDF; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mfhi = 1'b1; mflo = 1'b1;
    @(negedge clk);
    mfhi = 1'b0; mflo = 1'b0;
    total++; if (rdata !== 32'h1357_9BDF) begin bad++; $display("FAIL rd_priority got=%h exp=13579bdf", rdata); end
  endtask

  task automatic test_stall_read;
    int stall_err, rdata_err, seen;
    bit left;
    stall_err = 0; rdata_err = 0; seen = 0; left = 1'b0;
    @(negedge clk);
    wdata = 32'h5555_AAAA; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0; mflo = 1'b1;
    @(negedge clk);
    mflo = 1'b0;
    total++; if (rdata !== 32'h5555_AAAA) begin bad++; $display("FAIL preload_lo got=%h exp=5555aaaa", rdata); end
    mult_hi_in = 32'h1111_2222; mult_lo_in = 32'h0BAD_F00D; start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k >= 5) mflo = 1'b1;
      #1;
      if (k >= 5 && busy === 1'b1) begin
        seen++;
`ifdef HILO_BYPASS_EN
        if (done !== 1'b1 && stall !== 1'b1) stall_err++;
`else
        if (stall !== 1'b1) stall_err++;
`endif
        if (rdata !== 32'h5555_AAAA) rdata_err++;
      end else if (k >= 5) begin
        left = 1'b1;
        break;
      end
    end
    @(negedge clk);
    mflo = 1'b0;
    total++; if (!left || seen < 25) begin bad++; $display("FAIL stall_window got=%0d busy cycles exp>=25", seen); end
    total++; if (stall_err != 0) begin bad++; $display("FAIL stall_read got=%0d errors exp=0", stall_err); end
    total++; if (rdata_err != 0) begin bad++; $display("FAIL stall_rdata_hold got=%0d errors exp=0", rdata_err); end
    total++; if (rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL retry_lo got=%h exp=0badf00d", rdata); end
  endtask

  task automatic test_back_to_back;
    int op_n, done_n;
    op_n = 0; done_n = 0;
    @(negedge clk);
    mult_hi_in = 32'hCAFE_0001; mult_lo_in = 32'hCAFE_0002; start = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      start = (k == 10);
      mthi = (k == 10);
      wdata = 32'hFFFF_0000;
      #1;
      if (k == 10) begin
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL busy_write_stall got=%b exp=1", stall); end
      end
      if (mult_op === 1'b1) op_n++;
      if (done === 1'b1) done_n++;
    end
    start = 1'b0; mthi = 1'b0;
    total++; if (op_n != 1) begin bad++; $display("FAIL b2b_mult_op got=%0d exp=1", op_n); end
    total++; if (done_n != 1) begin bad++; $display("FAIL b2b_done got=%0d exp=1", done_n); end
    total++; if (hi !== 32'hCAFE_0001 || lo !== 32'hCAFE_0002) begin bad++; $display("FAIL b2b_result got=%h/%h exp=cafe0001/cafe0002", hi, lo); end
  endtask

  task automatic test_start_write;
    bit got;
    got = 1'b0;
    @(negedge clk);
    mult_hi_in = 32'h8888_8888; mult_lo_in = 32'h9999_9999;
    start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h7777_7777;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    total++; if (hi !== 32'h7777_7777 || lo !== 32'h7777_7777 || busy !== 1'b1) begin bad++; $display("FAIL start_write got=%h/%h busy=%b exp=77777777/77777777 busy=1", hi, lo, busy); end
    for (int k = 2; k <= 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    @(negedge clk);
    total++; if (!got) begin bad++; $display("FAIL start_write_done got=timeout exp=done"); end
    total++; if (hi !== 32'h8888_8888 || lo !== 32'h9999_9999) begin bad++; $display("FAIL start_write_capture got=%h/%h exp=88888888/99999999", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int done_n, busy_n;
    done_n = 0; busy_n = 0;
    @(negedge clk);
    mult_hi_in = 32'h4444_4444; mult_lo_in = 32'h5555_5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL midrst_hilo got=%h/%h exp=0/0", hi, lo); end
    total++; if (busy !== 1'b0 || rdata !== 32'h0) begin bad++; $display("FAIL midrst_busy_rdata got=%b/%h exp=0/0", busy, rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_n++;
      if (busy === 1'b1) busy_n++;
    end
    total++; if (done_n != 0 || busy_n != 0) begin bad++; $display("FAIL midrst_no_done got=%0d/%0d exp=0/0", done_n, busy_n); end
  endtask

  task automatic test_bypass;
    bit got;
    got = 1'b0;
    @(negedge clk);
    wdata = 32'h0F0F_0F0F; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mfhi = 1'b1;
    @(negedge clk);
    mfhi = 1'b0;
    mult_hi_in = 32'h1234_5678; mult_lo_in = 32'h0; start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin got = 1'b1; break; end
    end
    mfhi = 1'b1;
    #1;
    total++; if (!got) begin bad++; $display("FAIL bypass_done got=timeout exp=done"); end
`ifdef HILO_BYPASS_EN
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL bypass_stall got=%b exp=0", stall); end
`else
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL capture_stall got=%b exp=1", stall); end
`endif
    @(negedge clk);
    mfhi = 1'b0;
`ifdef HILO_BYPASS_EN
    total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL bypass_rdata got=%h exp=12345678", rdata); end
`else
    total++; if (rdata !== 32'h0F0F_0F0F) begin bad++; $display("FAIL capture_rdata_hold got=%h exp=0f0f0f0f", rdata); end
`endif
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL bypass_hi got=%h exp=12345678", hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_write_read();
    test_stall_read();
    test_back_to_back();
    test_start_write();
    test_reset_mid();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
